// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM state
// encoding, register-file write-source selects and the EXEC control bundle.
package control_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_DWORD  = 3'b011;
    localparam logic [2:0] F3_JALR   = 3'b000;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEMWB  = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DIN_MEM   = 2'b00,
        DIN_ALU   = 2'b01,
        DIN_PC4   = 2'b10,
        DIN_PCIMM = 2'b11
    } rf_din_sel_t;

    // Datapath controls asserted during EXEC for one instruction class.
    typedef struct packed {
        logic        sub;
        logic        we_rf;
        logic        we_mem;
        rf_din_sel_t rf_din_sel;
        logic        ula_din2_sel;
        logic        load_pc;
        logic        pc_next_sel;
        logic        pc_adder_sel;
    } exec_ctrl_t;

    // BRANCH funct3 values the datapath flags can resolve (010/011 are reserved).
    function automatic logic branch_f3_ok(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational instruction classifier: flags unsupported encodings, marks
// loads (which need the extra MEMWB cycle) and produces the EXEC controls.
module control_decoder
    import control_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output logic        illegal,
    output logic        is_load,
    output exec_ctrl_t  exec
);

    // Opcode/funct decode; anything not matched stays illegal with a null bundle.
    always_comb begin
        illegal = 1'b1;
        is_load = 1'b0;
        exec    = '0;
        case (opcode)
            OPC_OP: begin
                if (funct3 == F3_ADD) begin
                    illegal           = 1'b0;
                    exec.ula_din2_sel = 1'b0;
                    exec.sub          = funct7_5;
                    exec.rf_din_sel   = DIN_ALU;
                    exec.we_rf        = 1'b1;
                    exec.load_pc      = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    illegal           = 1'b0;
                    exec.ula_din2_sel = 1'b1;
                    exec.rf_din_sel   = DIN_ALU;
                    exec.we_rf        = 1'b1;
                    exec.load_pc      = 1'b1;
                end
            end
            OPC_LOAD: begin
                // Address computed here; the write-back and PC update happen in MEMWB.
                if (funct3 == F3_DWORD) begin
                    illegal           = 1'b0;
                    is_load           = 1'b1;
                    exec.ula_din2_sel = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_DWORD) begin
                    illegal           = 1'b0;
                    exec.ula_din2_sel = 1'b1;
                    exec.we_mem       = 1'b1;
                    exec.load_pc      = 1'b1;
                end
            end
            OPC_BRANCH: begin
                // Taken/not-taken is resolved in the PC block from the ALU flags.
                if (branch_f3_ok(funct3)) begin
                    illegal           = 1'b0;
                    exec.sub          = 1'b1;
                    exec.ula_din2_sel = 1'b0;
                    exec.pc_next_sel  = 1'b1;
                    exec.pc_adder_sel = 1'b0;
                    exec.load_pc      = 1'b1;
                end
            end
            OPC_JAL: begin
                illegal           = 1'b0;
                exec.rf_din_sel   = DIN_PC4;
                exec.we_rf        = 1'b1;
                exec.pc_next_sel  = 1'b1;
                exec.pc_adder_sel = 1'b0;
                exec.load_pc      = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == F3_JALR) begin
                    illegal           = 1'b0;
                    exec.rf_din_sel   = DIN_PC4;
                    exec.we_rf        = 1'b1;
                    exec.pc_next_sel  = 1'b1;
                    exec.pc_adder_sel = 1'b1;
                    exec.load_pc      = 1'b1;
                end
            end
            OPC_AUIPC: begin
                illegal           = 1'b0;
                exec.rf_din_sel   = DIN_PCIMM;
                exec.pc_adder_sel = 1'b0;
                exec.pc_next_sel  = 1'b0;
                exec.we_rf        = 1'b1;
                exec.load_pc      = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the RV64 single-issue datapath, plus the
// retired-instruction counter.
//
//   state  | meaning
//   INIT   | PC cleared (reset_pc), entered on reset
//   FETCH  | instruction register loads the word at the current PC
//   DECODE | encoding checked; illegal -> HALT
//   EXEC   | class-specific controls; loads continue to MEMWB
//   MEMWB  | data-memory word written to the register file, PC advances
//   HALT   | unsupported encoding seen; only reset leaves
module control_unit
    import control_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7_5,
    output logic               sub,
    output logic               WE_RF,
    output logic               WE_MEM,
    output logic [1:0]         RF_din_sel,
    output logic               ULA_din2_sel,
    output logic               load_pc,
    output logic               reset_pc,
    output logic               pc_next_sel,
    output logic               pc_adder_sel,
    output logic               halted,
    output logic [COUNT_W-1:0] retired_count
);

    state_t             state_q;
    state_t             state_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               illegal;
    logic               is_load;
    exec_ctrl_t         exec;

    control_decoder u_decoder (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .illegal  (illegal),
        .is_load  (is_load),
        .exec     (exec)
    );

    // State and retired-instruction counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_INIT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = illegal ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_d = is_load ? ST_MEMWB : ST_FETCH;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    // Moore output decode of state plus the registered instruction fields.
    always_comb begin
        sub          = 1'b0;
        WE_RF        = 1'b0;
        WE_MEM       = 1'b0;
        RF_din_sel   = DIN_MEM;
        ULA_din2_sel = 1'b0;
        load_pc      = 1'b0;
        reset_pc     = 1'b0;
        pc_next_sel  = 1'b0;
        pc_adder_sel = 1'b0;
        halted       = 1'b0;
        case (state_q)
            ST_INIT: begin
                reset_pc = 1'b1;
            end
            ST_EXEC: begin
                sub          = exec.sub;
                WE_RF        = exec.we_rf;
                WE_MEM       = exec.we_mem;
                RF_din_sel   = exec.rf_din_sel;
                ULA_din2_sel = exec.ula_din2_sel;
                load_pc      = exec.load_pc;
                pc_next_sel  = exec.pc_next_sel;
                pc_adder_sel = exec.pc_adder_sel;
            end
            ST_MEMWB: begin
                // ALU operand held so the memory address stays stable.
                ULA_din2_sel = 1'b1;
                RF_din_sel   = DIN_MEM;
                WE_RF        = 1'b1;
                load_pc      = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    // An instruction retires on the same edge its PC update lands.
    always_comb begin
        count_d = count_q;
        if (load_pc && (state_q != ST_INIT)) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    assign retired_count = count_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: every instruction class, illegal-encoding
// halts, reset in the middle of a load, and counter wrap.
module tb_control_unit;
    import control_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        sub;
    logic        WE_RF;
    logic        WE_MEM;
    logic [1:0]  RF_din_sel;
    logic        ULA_din2_sel;
    logic        load_pc;
    logic        reset_pc;
    logic        pc_next_sel;
    logic        pc_adder_sel;
    logic        halted;
    logic [31:0] retired_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count;

    control_unit #(.COUNT_W(32)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .sub           (sub),
        .WE_RF         (WE_RF),
        .WE_MEM        (WE_MEM),
        .RF_din_sel    (RF_din_sel),
        .ULA_din2_sel  (ULA_din2_sel),
        .load_pc       (load_pc),
        .reset_pc      (reset_pc),
        .pc_next_sel   (pc_next_sel),
        .pc_adder_sel  (pc_adder_sel),
        .halted        (halted),
        .retired_count (retired_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, reset_pc, pc_next_sel, pc_adder_sel, halted}
    function automatic logic [10:0] mk(input logic s, input logic wrf, input logic wmem,
                                       input logic [1:0] din, input logic u2, input logic lpc,
                                       input logic rpc, input logic pns, input logic pas,
                                       input logic hlt);
        return {s, wrf, wmem, din, u2, lpc, rpc, pns, pas, hlt};
    endfunction

    function automatic logic [10:0] outs();
        return {sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, reset_pc,
                pc_next_sel, pc_adder_sel, halted};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Enter reset, check it, release with INIT lasting one cycle, end in FETCH.
    task automatic do_reset(input string tag);
        RST_N = 1'b0;
        #1;
        exp_count = 32'd0;
        chk({tag, "_rst_outs"}, 32'(outs()), 32'(mk(0,0,0,2'b00,0,0,1,0,0,0)));
        chk({tag, "_rst_cnt"}, retired_count, exp_count);
        tick();
        RST_N = 1'b1;
        chk({tag, "_init_st"}, 32'(dut.state_q), 32'(ST_INIT));
        chk({tag, "_init_rpc"}, 32'(reset_pc), 32'd1);
        tick();
        chk({tag, "_fetch_st"}, 32'(dut.state_q), 32'(ST_FETCH));
        chk({tag, "_fetch_cnt"}, retired_count, exp_count);
    endtask

    // Runs one legal instruction starting in FETCH; ends in the next FETCH.
    task automatic do_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic f75, input logic [10:0] exp_exec,
                            input bit load, input logic [10:0] exp_mwb);
        chk({tag, "_fetch"}, 32'(outs()), 32'd0);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f75;
        tick();
        chk({tag, "_dec_st"}, 32'(dut.state_q), 32'(ST_DECODE));
        chk({tag, "_dec_outs"}, 32'(outs()), 32'd0);
        tick();
        chk({tag, "_exec_st"}, 32'(dut.state_q), 32'(ST_EXEC));
        chk({tag, "_exec_outs"}, 32'(outs()), 32'(exp_exec));
        if (load) begin
            tick();
            chk({tag, "_mwb_st"}, 32'(dut.state_q), 32'(ST_MEMWB));
            chk({tag, "_mwb_outs"}, 32'(outs()), 32'(exp_mwb));
            chk({tag, "_mwb_cnt"}, retired_count, exp_count);
        end
        tick();
        exp_count = exp_count + 32'd1;
        chk({tag, "_next_st"}, 32'(dut.state_q), 32'(ST_FETCH));
        chk({tag, "_cnt"}, retired_count, exp_count);
    endtask

    // Illegal encoding: DECODE then HALT, frozen for 10 cycles.
    task automatic do_illegal(input string tag, input logic [6:0] op, input logic [2:0] f3);
        opcode   = op;
        funct3   = f3;
        funct7_5 = 1'b0;
        tick();
        chk({tag, "_dec_st"}, 32'(dut.state_q), 32'(ST_DECODE));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk({tag, "_halt_st"}, 32'(dut.state_q), 32'(ST_HALT));
            chk({tag, "_halt_outs"}, 32'(outs()), 32'(mk(0,0,0,2'b00,0,0,0,0,0,1)));
            chk({tag, "_halt_cnt"}, retired_count, exp_count);
        end
    endtask

    initial begin
        RST_N     = 1'b0;
        opcode    = 7'd0;
        funct3    = 3'd0;
        funct7_5  = 1'b0;
        exp_count = 32'd0;
        tick();
        do_reset("por");

        do_instr("add",   OPC_OP,     3'b000, 1'b0, mk(0,1,0,2'b01,0,1,0,0,0,0), 1'b0, 11'd0);
        do_instr("sub",   OPC_OP,     3'b000, 1'b1, mk(1,1,0,2'b01,0,1,0,0,0,0), 1'b0, 11'd0);
        chk("cnt_after_add_sub", retired_count, 32'd2);
        do_instr("addi",  OPC_OP_IMM, 3'b000, 1'b1, mk(0,1,0,2'b01,1,1,0,0,0,0), 1'b0, 11'd0);
        do_instr("ld",    OPC_LOAD,   3'b011, 1'b0, mk(0,0,0,2'b00,1,0,0,0,0,0), 1'b1,
                 mk(0,1,0,2'b00,1,1,0,0,0,0));
        do_instr("sd",    OPC_STORE,  3'b011, 1'b0, mk(0,0,1,2'b00,1,1,0,0,0,0), 1'b0, 11'd0);
        do_instr("beq",   OPC_BRANCH, 3'b000, 1'b0, mk(1,0,0,2'b00,0,1,0,1,0,0), 1'b0, 11'd0);
        do_instr("bgeu",  OPC_BRANCH, 3'b111, 1'b0, mk(1,0,0,2'b00,0,1,0,1,0,0), 1'b0, 11'd0);
        do_instr("jal",   OPC_JAL,    3'b101, 1'b0, mk(0,1,0,2'b10,0,1,0,1,0,0), 1'b0, 11'd0);
        do_instr("jalr",  OPC_JALR,   3'b000, 1'b0, mk(0,1,0,2'b10,0,1,0,1,1,0), 1'b0, 11'd0);
        do_instr("auipc", OPC_AUIPC,  3'b010, 1'b0, mk(0,1,0,2'b11,0,1,0,0,0,0), 1'b0, 11'd0);
        chk("cnt_after_seq", retired_count, 32'd10);

        do_illegal("lui", 7'b0110111, 3'b000);
        do_reset("rst_lui");
        do_instr("add2", OPC_OP, 3'b000, 1'b0, mk(0,1,0,2'b01,0,1,0,0,0,0), 1'b0, 11'd0);
        do_illegal("br010", OPC_BRANCH, 3'b010);
        do_reset("rst_br");
        do_illegal("sub_f3", OPC_OP, 3'b001);
        do_reset("rst_f3");

        // Reset pulled during a load's write-back cycle.
        opcode = OPC_LOAD;
        funct3 = 3'b011;
        tick();
        tick();
        tick();
        chk("ldrst_mwb_we", 32'(WE_RF), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("ldrst_we_drop", 32'(WE_RF), 32'd0);
        chk("ldrst_lpc_drop", 32'(load_pc), 32'd0);
        chk("ldrst_cnt", retired_count, 32'd0);
        chk("ldrst_rpc", 32'(reset_pc), 32'd1);
        do_reset("ldrst");

        // Counter wrap: preset to all-ones in EXEC, the retiring edge wraps to 0.
        opcode = OPC_AUIPC;
        funct3 = 3'b000;
        tick();
        tick();
        chk("wrap_exec_lpc", 32'(load_pc), 32'd1);
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        tick();
        chk("wrap_cnt", retired_count, 32'd0);
        chk("wrap_st", 32'(dut.state_q), 32'(ST_FETCH));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
